serial_add_ctrl: RTL

- Bit-serial adder sequencer. On a start handshake it captures two WIDTH-bit operands into internal right-shift registers.
- Over WIDTH shift cycles it clocks them LSB-first through a 1-bit full adder with a registered carry, accumulating the sum into a result shift register.
- When finished it publishes the sum and carry-out with a done pulse.
- It sits between the parallel datapath and the serial shift_register primitives: it drives the shared shift enable and sequences the add.

---
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands on start, adds them
// LSB-first over WIDTH shift cycles through a 1-bit full adder with a
// registered carry, then publishes sum/cout with a one-cycle done pulse.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; operands captured on the accepting edge
//   S_RUN  | one operand bit per cycle through the full adder, shift_en=1
//   S_DONE | sum/cout just updated; done=1 for this single cycle
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             shift_en,
  output logic             sum_bit,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_n;
  logic             accept;
  logic             last;

  // Full-adder slice on the current LSBs and the registered carry.
  always_comb begin
    sum_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_n = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    accept  = (state_q == S_IDLE) && start && !abort;
    last    = (cnt_q == LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; abort wins over start and ends a run without done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q == S_RUN);
    shift_en = (state_q == S_RUN);
    done     = (state_q == S_DONE);
  end

  // Datapath next values: load on accept, shift in RUN, publish on last bit.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = cin;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_RUN && !abort) begin
      acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
      carry_d = carry_n;
      a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
      if (last) begin
        sum_d  = {sum_bit, acc_q[WIDTH-1:1]};
        cout_d = carry_n;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
